// File: rtl/mem_bus_responder.sv
// Memory-port responder: accepts valid/ready requests under external stall and
// latency choices, returns one in-order response per request, flags protocol
// violations. Optional backing store enabled by defining MEM_RESP_MODEL_EN.
module mem_bus_responder #(
  parameter int unsigned Xlen       = 64,
  parameter int unsigned MaskBits   = Xlen / 8,
  parameter int unsigned Depth      = 4,
  parameter int unsigned MaxLatency = 7,
  parameter int unsigned ModelWords = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [Xlen-1:0]                   addr_i,
  input  logic [Xlen-1:0]                   wdata_i,
  input  logic [MaskBits-1:0]               wmask_i,
  output logic                              rvalid_o,
  output logic [Xlen-1:0]                   rdata_o,
  input  logic                              stall_i,
  input  logic [$clog2(MaxLatency+1)-1:0]   lat_i,
  input  logic [Xlen-1:0]                   rdata_src_i,
  output logic [$clog2(Depth+1)-1:0]        pending_o,
  output logic                              err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned LatW = $clog2(MaxLatency + 1);
  localparam logic [LatW-1:0] MaxLat = LatW'(MaxLatency);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Xlen-1:0]     q_addr  [Depth];
  logic [Xlen-1:0]     q_wdata [Depth];
  logic [MaskBits-1:0] q_wmask [Depth];
  logic [LatW-1:0]     q_cnt   [Depth];

  logic [PtrW-1:0] head, tail;
  logic [CntW-1:0] count;
  logic [Depth-1:0] ent_valid;

  logic            accept, resp;
  logic [LatW-1:0] lat_eff, lat_load;
  logic [Xlen-1:0] read_word;

  logic                wait_q, err_q, viol;
  logic [Xlen-1:0]     addr_q, wdata_q;
  logic [MaskBits-1:0] wmask_q;

  assign ready_o   = !stall_i && (count != FullCnt);
  assign accept    = valid_i && ready_o;
  assign resp      = (count != '0) && (q_cnt[head] == '0);
  assign rvalid_o  = resp;
  assign pending_o = count;
  assign err_o     = err_q;

  always_comb begin
    if (lat_i == '0)
      lat_eff = LatW'(1);
    else if (lat_i >= MaxLat)
      lat_eff = MaxLat;
    else
      lat_eff = lat_i;
    lat_load = lat_eff - LatW'(1);
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    ent_valid = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      logic [PtrW-1:0] off;
      off = PtrW'(i) - head;
      ent_valid[i] = CntW'(off) < count;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (resp && (q_wmask[head] == '0))
      rdata_o = read_word;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        q_addr[i]  <= '0;
        q_wdata[i] <= '0;
        q_wmask[i] <= '0;
        q_cnt[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (ent_valid[i] && (q_cnt[i] != '0))
          q_cnt[i] <= q_cnt[i] - LatW'(1);
      end
      if (accept) begin
        q_addr[tail]  <= addr_i;
        q_wdata[tail] <= wdata_i;
        q_wmask[tail] <= wmask_i;
        q_cnt[tail]   <= lat_load;
        tail          <= tail + PtrW'(1);
      end
      if (resp)
        head <= head + PtrW'(1);
      if (accept && !resp)
        count <= count + CntW'(1);
      else if (!accept && resp)
        count <= count - CntW'(1);
    end
  end

  // A request left waiting last cycle must be held unchanged until accepted.
  always_comb begin
    viol = wait_q && (!valid_i || (addr_i != addr_q) ||
                      (wdata_i != wdata_q) || (wmask_i != wmask_q));
    if ($isunknown(valid_i))
      viol = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      wait_q  <= valid_i && !ready_o;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      wmask_q <= wmask_i;
      err_q   <= err_q | viol;
    end
  end

`ifdef MEM_RESP_MODEL_EN
  localparam int unsigned IdxW = $clog2(ModelWords);
  localparam int unsigned OffW = $clog2(MaskBits);

  logic [Xlen-1:0] store [ModelWords];
  logic [IdxW-1:0] idx;
  logic            model_unused;

  assign idx          = q_addr[head][OffW +: IdxW];
  assign read_word    = store[idx];
  assign model_unused = ^{rdata_src_i, q_addr[head]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < ModelWords; w++)
        store[w] <= '0;
    end else if (resp && (q_wmask[head] != '0)) begin
      for (int unsigned b = 0; b < MaskBits; b++) begin
        if (q_wmask[head][b])
          store[idx][b*8 +: 8] <= q_wdata[head][b*8 +: 8];
      end
    end
  end
`else
  logic model_unused;

  assign read_word    = rdata_src_i;
  assign model_unused = ^{q_addr[head], q_wdata[head]};
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized + directed bench for mem_bus_responder with a request-level model:
// each accepted request gets a due cycle max(accept+L, previous due+1).
module tb_mem_bus_responder;

  localparam int Depth = 4;
  localparam int MaxLat = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  wmask = '0;
  logic        rvalid;
  logic [63:0] rdata;
  logic        stall = 1'b0;
  logic [2:0]  lat = '0;
  logic [63:0] src = '0;
  logic [2:0]  pending;
  logic        err;

  int tests = 0;
  int fails = 0;

  mem_bus_responder #(
    .Xlen(64), .MaskBits(8), .Depth(Depth), .MaxLatency(MaxLat), .ModelWords(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .rvalid_o(rvalid), .rdata_o(rdata), .stall_i(stall), .lat_i(lat),
    .rdata_src_i(src), .pending_o(pending), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and per-cycle compare ----------------
  typedef struct {
    int          due;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  req_t        mq[$];
  logic [63:0] mstore [16];
  int          cyc = 0;
  int          last_due = 0;
  bit          exp_err = 0;
  bit          prev_wait = 0;
  logic [63:0] prev_addr, prev_wdata;
  logic [7:0]  prev_wmask;

  always @(negedge clk) begin
    bit          exp_ready, exp_rv;
    logic [63:0] exp_rd;
    int          l, due;
    req_t        r;
    cyc++;
    if (rst) begin
      mq.delete();
      last_due = 0;
      exp_err = 0;
      prev_wait = 0;
      for (int w = 0; w < 16; w++) mstore[w] = '0;
      check("rst_pending", pending, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", err, 0);
      check("rst_ready", ready, !stall);
    end else begin
      exp_ready = !stall && (mq.size() != Depth);
      exp_rv = (mq.size() > 0) && (mq[0].due == cyc);
      exp_rd = '0;
      if (exp_rv && mq[0].wmask == 0) begin
`ifdef MEM_RESP_MODEL_EN
        exp_rd = mstore[mq[0].addr[6:3]];
`else
        exp_rd = src;
`endif
      end
      check("ready", ready, exp_ready);
      check("rvalid", rvalid, exp_rv);
      check("rdata", rdata, exp_rd);
      check("pending", pending, mq.size());
      check("err", err, exp_err);
      if (exp_rv) begin
        r = mq.pop_front();
        for (int b = 0; b < 8; b++)
          if (r.wmask[b]) mstore[r.addr[6:3]][b*8 +: 8] = r.wdata[b*8 +: 8];
      end
      if (valid && exp_ready) begin
        l = (lat == 0) ? 1 : ((int'(lat) > MaxLat) ? MaxLat : int'(lat));
        due = cyc + l;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{due: due, addr: addr, wdata: wdata, wmask: wmask});
      end
      if (prev_wait && (!valid || addr != prev_addr || wdata != prev_wdata || wmask != prev_wmask))
        exp_err = 1;
      prev_wait = valid && !exp_ready;
      prev_addr = addr;
      prev_wdata = wdata;
      prev_wmask = wmask;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lats[4];
    int          pend_tab[6];
    bit          hold;
    logic [63:0] exp_w;
    lats = '{5, 1, 1, 1};
    pend_tab = '{4, 4, 3, 2, 1, 0};

    repeat (3) step();
    rst = 1'b0;
    step();

`ifdef MEM_RESP_MODEL_EN
    // Partial write then read-back through the backing store.
    valid = 1; addr = 64'h40; wdata = 64'h1122334455667788; wmask = 8'h0F; lat = 1;
    step();
    wmask = 8'h00; wdata = '0;
    @(negedge clk);
    check("model_wr_rvalid", rvalid, 1);
    check("model_wr_rdata", rdata, 0);
    step();
    valid = 0;
    @(negedge clk);
    check("model_rd_rvalid", rvalid, 1);
    check("model_rd_rdata", rdata, 64'h0000000055667788);
    step();
`endif

    // Single read, latency 3.
    valid = 1; addr = 64'h100; wmask = 0; lat = 3; src = 64'hDEAD;
    @(negedge clk);
    check("d1_ready", ready, 1);
    check("d1_pending0", pending, 0);
    step();
    valid = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("d1_rvalid", rvalid, k == 3);
      check("d1_pending", pending, (k <= 3) ? 1 : 0);
`ifndef MEM_RESP_MODEL_EN
      if (k == 3) check("d1_rdata", rdata, 64'hDEAD);
`endif
      step();
    end

    // Fill to Depth with latencies 5,1,1,1.
    for (int j = 0; j < 4; j++) begin
      valid = 1; lat = 3'(lats[j]); addr = 64'h200 + 64'(8 * j);
      @(negedge clk);
      check("d2_ready_accept", ready, 1);
      step();
    end
    valid = 0;
    for (int k = 4; k <= 9; k++) begin
      @(negedge clk);
      check("d2_rvalid", rvalid, (k >= 5) && (k <= 8));
      check("d2_pending", pending, pend_tab[k-4]);
      if (k <= 5) check("d2_ready_full", ready, 0);
      step();
    end

    // Latency 0 behaves as 1; maximum latency 7.
    valid = 1; lat = 0; addr = 64'h300;
    step();
    valid = 0;
    @(negedge clk);
    check("d3_lat0_rvalid", rvalid, 1);
    step();
    valid = 1; lat = 7;
    step();
    valid = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("d3_lat7_rvalid", rvalid, k == 7);
      step();
    end

    // Clean request held through 3 stall cycles.
    stall = 1; valid = 1; addr = 64'h310; lat = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("d4_stalled_ready", ready, 0);
      step();
    end
    stall = 0;
    step();
    valid = 0;
    repeat (3) step();
    @(negedge clk);
    check("d4_clean_err", err, 0);
    step();

    // Randomized, protocol-respecting traffic.
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        valid = ($urandom_range(0, 3) != 0);
        addr = {$urandom(), $urandom()};
        wdata = {$urandom(), $urandom()};
        wmask = ($urandom_range(0, 1) == 1) ? 8'($urandom()) : 8'h00;
      end
      stall = ($urandom_range(0, 3) == 0);
      lat = 3'($urandom());
      src = {$urandom(), $urandom()};
      @(negedge clk);
      hold = valid && !ready;
      step();
    end
    valid = 0; stall = 0;
    repeat (12) step();

    // Address change while a stalled request waits.
    stall = 1; valid = 1; addr = 64'h500; wmask = 0;
    step(); step();
    addr = 64'h508;
    @(negedge clk);
    check("d5_err_before", err, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("d5_err_sticky", err, 1);
      step();
    end
    valid = 0; stall = 0;
    step();

    // Reset with 3 outstanding requests.
    for (int j = 0; j < 3; j++) begin
      valid = 1; lat = 7; wmask = (j == 0) ? 8'hFF : 8'h00; addr = 64'h40; wdata = '1;
      step();
    end
    valid = 0; wmask = 0;
    @(negedge clk);
    check("d6_pending3", pending, 3);
    step();
    rst = 1;
    @(negedge clk);
    check("d6_rst_pending", pending, 0);
    check("d6_rst_rvalid", rvalid, 0);
    step();
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      check("d6_no_stale_rvalid", rvalid, 0);
      step();
    end
    valid = 1; addr = 64'h40; lat = 1; src = 64'h1234;
    step();
    valid = 0;
`ifdef MEM_RESP_MODEL_EN
    exp_w = 64'h0;
`else
    exp_w = 64'h1234;
`endif
    @(negedge clk);
    check("d6_read_after_rst_rvalid", rvalid, 1);
    check("d6_read_after_rst_rdata", rdata, exp_w);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
